// File: rtl/multiexp_pkg.sv
// Shared constants and types for the multiexp scalar/point feeder.
package multiexp_pkg;

  localparam int MAX_IN_DEF = 1024;
  localparam int REC_BEATS  = 7;
  localparam int PNT_WORDS  = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_REPLAY = 2'd2
  } feed_state_e;

  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Minimal val/rdy stream with packet delimiters and a control side-band.
interface if_axi_stream #(
  parameter int DAT_BITS = 32,
  parameter int CTL_BITS = 16
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;

  modport source (output val, sop, eop, dat, ctl, input rdy);
  modport sink   (input val, sop, eop, dat, ctl, output rdy);
endinterface

// File: rtl/multiexp_feed_skid.sv
// Two-entry register FIFO between the RAM read pipe and the output stream.
// The writer must only push when the occupancy it tracks allows it.
module multiexp_feed_skid #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         wr_val,
  input  logic [W-1:0] wr_dat,
  output logic         rd_val,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         afull
);

  logic [1:0]   cnt_r;
  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic         pop_s;

  assign rd_val = (cnt_r != 2'd0);
  assign rd_dat = head_r;
  assign full   = (cnt_r == 2'd2);
  assign afull  = (cnt_r == 2'd1);
  assign pop_s  = rd_val && rd_rdy;

  // Head/tail storage and occupancy update
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt_r  <= 2'd0;
      head_r <= {W{1'b0}};
      tail_r <= {W{1'b0}};
    end else begin
      case (cnt_r)
        2'd0: begin
          if (wr_val) begin
            head_r <= wr_dat;
            cnt_r  <= 2'd1;
          end
        end
        2'd1: begin
          if (wr_val && pop_s) begin
            head_r <= wr_dat;
          end else if (wr_val) begin
            tail_r <= wr_dat;
            cnt_r  <= 2'd2;
          end else if (pop_s) begin
            cnt_r  <= 2'd0;
          end
        end
        2'd2: begin
          if (pop_s) begin
            head_r <= tail_r;
            if (wr_val) tail_r <= wr_dat;
            else        cnt_r  <= 2'd1;
          end
        end
        default: cnt_r <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/multiexp_fp2_feeder.sv
// Captures (scalar, G2 point) records from the load stream, then replays them
// KEY_BITS times with the scalar shifted left by the pass number.
module multiexp_fp2_feeder
  import multiexp_pkg::*;
#(
  parameter type FE_TYPE  = logic [255:0],
  parameter int  KEY_BITS = 256,
  parameter int  CTL_BITS = 16,
  parameter int  MAX_IN   = MAX_IN_DEF,
  localparam int DAT_BITS = $bits(FE_TYPE),
  localparam int NW       = $clog2(MAX_IN + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [NW-1:0] i_num_in,
  if_axi_stream.sink    i_load_if,
  if_axi_stream.source  o_pnt_scl_if,
  output logic          o_busy,
  output logic          o_err
);

  localparam int RW  = clog2_min1(MAX_IN);
  localparam int PAW = clog2_min1(MAX_IN * PNT_WORDS);
  localparam int PSW = clog2_min1(KEY_BITS);
  localparam int SW  = DAT_BITS + 2 + CTL_BITS;

  feed_state_e         state_r;
  logic [NW-1:0]       num_in_r;
  logic [CTL_BITS-1:0] ctl_l_r;
  logic [2:0]          b_r;
  logic [NW-1:0]       r_r;
  logic [PAW-1:0]      pa_r;
  logic [PSW-1:0]      pass_r;
  logic                issue_done_r;
  logic                ld_rdy_r;
  logic                busy_r;
  logic                err_r;

  logic                rd_vld_r;
  logic                rd_sop_r;
  logic                rd_eop_r;
  logic [PSW-1:0]      rd_pass_r;
  logic [KEY_BITS-1:0] scal_q_r;
  logic [DAT_BITS-1:0] pnt_q_r;

  logic [KEY_BITS-1:0] scal_ram [MAX_IN];
  logic [DAT_BITS-1:0] pnt_ram  [MAX_IN*PNT_WORDS];

  logic                ld_beat_s;
  logic                num_ok_s;
  logic                fmt_ok_s;
  logic                last_rec_s;
  logic                scal_we_s;
  logic [RW-1:0]       scal_wa_s;
  logic                pnt_we_s;
  logic                issue_ok_s;
  logic                issue_s;
  logic                pop_s;
  logic                replay_fin_s;
  logic [KEY_BITS-1:0] shift_s;
  logic [DAT_BITS-1:0] beat_dat_s;
  logic [CTL_BITS-1:0] ctl_out_s;
  logic                sk_val_s;
  logic                sk_full_s;
  logic                sk_afull_s;
  logic [SW-1:0]       sk_dat_s;

  assign ld_beat_s  = i_load_if.val && ld_rdy_r;
  assign num_ok_s   = (i_num_in != {NW{1'b0}}) && (i_num_in <= NW'(MAX_IN));
  assign fmt_ok_s   = (i_load_if.sop == (b_r == 3'd0)) && (i_load_if.eop == (b_r == 3'd6));
  assign last_rec_s = (r_r == (num_in_r - NW'(1)));

  assign scal_we_s = ((state_r == ST_IDLE) && ld_beat_s && i_load_if.sop && num_ok_s) ||
                     ((state_r == ST_LOAD) && ld_beat_s && fmt_ok_s && (b_r == 3'd0));
  assign scal_wa_s = (state_r == ST_LOAD) ? r_r[RW-1:0] : {RW{1'b0}};
  assign pnt_we_s  = (state_r == ST_LOAD) && ld_beat_s && fmt_ok_s && (b_r != 3'd0);

  // Only issue a read if the skid can still hold it once it lands next cycle
  assign pop_s      = sk_val_s && o_pnt_scl_if.rdy;
  assign issue_ok_s = sk_full_s  ? (pop_s && !rd_vld_r) :
                      sk_afull_s ? (pop_s || !rd_vld_r) : 1'b1;
  assign issue_s      = (state_r == ST_REPLAY) && !issue_done_r && issue_ok_s;
  assign replay_fin_s = issue_done_r && !rd_vld_r && sk_afull_s && pop_s;

  assign shift_s    = scal_q_r << rd_pass_r;
  assign beat_dat_s = rd_sop_r ? DAT_BITS'(shift_s) : pnt_q_r;
  assign ctl_out_s  = ctl_l_r & ~CTL_BITS'(1);

  // Record storage: load-side writes and replay-side registered reads
  always_ff @(posedge i_clk) begin
    if (scal_we_s) scal_ram[scal_wa_s] <= i_load_if.dat[KEY_BITS-1:0];
    if (pnt_we_s)  pnt_ram[pa_r]       <= i_load_if.dat;
    if (issue_s) begin
      scal_q_r <= scal_ram[r_r[RW-1:0]];
      pnt_q_r  <= pnt_ram[pa_r];
    end
  end

  // Beat attributes travelling alongside the RAM read data
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rd_vld_r  <= 1'b0;
      rd_sop_r  <= 1'b0;
      rd_eop_r  <= 1'b0;
      rd_pass_r <= {PSW{1'b0}};
    end else begin
      rd_vld_r <= issue_s;
      if (issue_s) begin
        rd_sop_r  <= (b_r == 3'd0);
        rd_eop_r  <= (b_r == 3'd6);
        rd_pass_r <= pass_r;
      end
    end
  end

  // Control FSM: capture, protocol check and replay sequencing
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r      <= ST_IDLE;
      num_in_r     <= {NW{1'b0}};
      ctl_l_r      <= {CTL_BITS{1'b0}};
      b_r          <= 3'd0;
      r_r          <= {NW{1'b0}};
      pa_r         <= {PAW{1'b0}};
      pass_r       <= {PSW{1'b0}};
      issue_done_r <= 1'b0;
      ld_rdy_r     <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          ld_rdy_r <= 1'b1;
          busy_r   <= 1'b0;
          if (ld_beat_s) begin
            num_in_r <= i_num_in;
            ctl_l_r  <= i_load_if.ctl;
            if (i_load_if.sop && num_ok_s) begin
              state_r <= ST_LOAD;
              busy_r  <= 1'b1;
              b_r     <= 3'd1;
              r_r     <= {NW{1'b0}};
              pa_r    <= {PAW{1'b0}};
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (ld_beat_s) begin
            if (!fmt_ok_s) begin
              err_r   <= 1'b1;
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end else if (b_r == 3'd6) begin
              b_r  <= 3'd0;
              pa_r <= pa_r + PAW'(1);
              if (last_rec_s) begin
                state_r      <= ST_REPLAY;
                ld_rdy_r     <= 1'b0;
                r_r          <= {NW{1'b0}};
                pa_r         <= {PAW{1'b0}};
                pass_r       <= {PSW{1'b0}};
                issue_done_r <= 1'b0;
              end else begin
                r_r <= r_r + NW'(1);
              end
            end else begin
              b_r <= b_r + 3'd1;
              if (b_r != 3'd0) pa_r <= pa_r + PAW'(1);
            end
          end
        end
        ST_REPLAY: begin
          if (issue_s) begin
            if (b_r == 3'd6) begin
              b_r  <= 3'd0;
              pa_r <= pa_r + PAW'(1);
              if (last_rec_s) begin
                r_r  <= {NW{1'b0}};
                pa_r <= {PAW{1'b0}};
                if (pass_r == PSW'(KEY_BITS - 1)) issue_done_r <= 1'b1;
                else                              pass_r       <= pass_r + PSW'(1);
              end else begin
                r_r <= r_r + NW'(1);
              end
            end else begin
              b_r <= b_r + 3'd1;
              if (b_r != 3'd0) pa_r <= pa_r + PAW'(1);
            end
          end
          if (replay_fin_s) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            ld_rdy_r <= 1'b1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          busy_r   <= 1'b0;
          ld_rdy_r <= 1'b0;
        end
      endcase
    end
  end

  multiexp_feed_skid #(.W(SW)) u_skid (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .wr_val (rd_vld_r),
    .wr_dat ({beat_dat_s, rd_sop_r, rd_eop_r, ctl_out_s}),
    .rd_val (sk_val_s),
    .rd_rdy (o_pnt_scl_if.rdy),
    .rd_dat (sk_dat_s),
    .full   (sk_full_s),
    .afull  (sk_afull_s)
  );

  assign o_pnt_scl_if.val = sk_val_s;
  assign {o_pnt_scl_if.dat, o_pnt_scl_if.sop, o_pnt_scl_if.eop, o_pnt_scl_if.ctl} = sk_dat_s;
  assign i_load_if.rdy    = ld_rdy_r;
  assign o_busy           = busy_r;
  assign o_err            = err_r;

endmodule

// File: tb/tb_multiexp_fp2_feeder.sv
// Bench for multiexp_fp2_feeder: KEY_BITS=4, MAX_IN=8, 16-bit elements.
module tb_multiexp_fp2_feeder;

  localparam int KB = 4;
  localparam int MI = 8;
  localparam int DB = 16;
  localparam int CB = 16;

  typedef struct {
    logic [DB-1:0] dat;
    logic          sop;
    logic          eop;
    logic [CB-1:0] ctl;
  } beat_t;

  typedef struct {
    logic [3:0] num;
    logic       sop;
    logic       eop;
    int         exp_err;
    logic       exp_busy;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] num_in = 4'd0;
  logic       busy;
  logic       err;

  if_axi_stream #(.DAT_BITS(DB), .CTL_BITS(CB)) ld_if ();
  if_axi_stream #(.DAT_BITS(DB), .CTL_BITS(CB)) out_if ();

  multiexp_fp2_feeder #(
    .FE_TYPE (logic [DB-1:0]),
    .KEY_BITS(KB),
    .CTL_BITS(CB),
    .MAX_IN  (MI)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_num_in    (num_in),
    .i_load_if   (ld_if),
    .o_pnt_scl_if(out_if),
    .o_busy      (busy),
    .o_err       (err)
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            err_cnt = 0;
  int            err_exp = 0;
  logic [KB-1:0] scal_a [MI];
  logic [DB-1:0] pnt_a  [MI*6];
  beat_t         exp_q  [$];
  logic [3:0]    sc_seen[$];
  logic [DB-1:0] last_dat;
  logic          last_eop;

  always @(negedge clk) if (err) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: every pass replays all records; scalar is (s << pass) mod 2^KB
  task automatic build_exp(input int n, input logic [CB-1:0] ctl);
    exp_q.delete();
    for (int p = 0; p < KB; p++)
      for (int r = 0; r < n; r++) begin
        int sv;
        sv = (int'(scal_a[r]) << p) % (1 << KB);
        exp_q.push_back('{dat: DB'(sv), sop: 1'b1, eop: 1'b0, ctl: ctl & 16'hFFFE});
        for (int w = 0; w < 6; w++)
          exp_q.push_back('{dat: pnt_a[r*6+w], sop: 1'b0, eop: (w == 5), ctl: ctl & 16'hFFFE});
      end
  endtask

  task automatic rand_data(input int n);
    for (int r = 0; r < n; r++) begin
      scal_a[r] = KB'($urandom);
      for (int w = 0; w < 6; w++) pnt_a[r*6+w] = DB'($urandom);
    end
  endtask

  task automatic load_beat(input logic [DB-1:0] d, input logic s, input logic e, input logic [CB-1:0] c);
    int k;
    ld_if.val = 1'b1; ld_if.dat = d; ld_if.sop = s; ld_if.eop = e; ld_if.ctl = c;
    k = 0;
    while (!ld_if.rdy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k == 100) check("load_rdy_timeout", 64'(ld_if.rdy), 64'd1);
    @(negedge clk);
  endtask

  task automatic load_recs(input int n, input logic [CB-1:0] ctl, input int bad_b);
    for (int r = 0; r < n; r++)
      for (int b = 0; b < 7; b++) begin
        logic [DB-1:0] tmp;
        logic [DB-1:0] d;
        logic          e;
        tmp = DB'($urandom);
        d = (b == 0) ? {tmp[DB-1:KB], scal_a[r]} : pnt_a[r*6+b-1];
        e = (b == 6) || (r == 0 && b == bad_b);
        load_beat(d, (b == 0), e, ctl);
        if (r == 0 && b == bad_b) begin
          ld_if.val = 1'b0;
          return;
        end
      end
    ld_if.val = 1'b0;
  endtask

  task automatic run_replay(input bit rnd, input int abort_at, output int first_val);
    int             idx;
    int             cyc;
    int             limit;
    int             extra;
    bit             stall;
    logic [2*DB+2:0] held;
    idx = 0; cyc = 0; stall = 0; held = '0; first_val = -1;
    limit = exp_q.size() * 4 + 100;
    sc_seen.delete();
    while (idx < exp_q.size() && cyc < limit) begin
      if (stall)
        check("stall_hold", 64'({out_if.val, out_if.sop, out_if.eop, out_if.ctl, out_if.dat}), 64'(held));
      if (first_val < 0 && out_if.val) first_val = cyc;
      out_if.rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = out_if.val && !out_if.rdy;
      held  = {1'b1, out_if.sop, out_if.eop, out_if.ctl, out_if.dat};
      if (out_if.val && out_if.rdy) begin
        check($sformatf("beat%0d", idx), 64'({out_if.sop, out_if.eop, out_if.ctl, out_if.dat}),
              64'({exp_q[idx].sop, exp_q[idx].eop, exp_q[idx].ctl, exp_q[idx].dat}));
        if (out_if.sop) sc_seen.push_back(out_if.dat[3:0]);
        last_dat = out_if.dat;
        last_eop = out_if.eop;
        idx++;
      end
      if (idx == abort_at) return;
      @(negedge clk);
      cyc++;
    end
    out_if.rdy = 1'b1;
    if (idx < exp_q.size()) check("replay_timeout", 64'(idx), 64'(exp_q.size()));
    check("idle_after_replay", 64'({busy, out_if.val}), 64'd0);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_if.val) extra++;
    end
    check("no_extra_beats", 64'(extra), 64'd0);
    check("load_rdy_after_replay", 64'(ld_if.rdy), 64'd1);
  endtask

  task automatic setup_t1();
    scal_a[0] = 4'b1011;
    scal_a[1] = 4'b0110;
    for (int i = 0; i < 12; i++) pnt_a[i] = 16'h1000 + 16'(i * 17);
  endtask

  ev_t           ev [5];
  logic [3:0]    sc_ref [8];
  int            fv;
  int            e0;
  int            vseen;
  int            n;
  logic [CB-1:0] c;

  initial begin
    ev[0] = '{num: 4'd0,  sop: 1'b1, eop: 1'b0, exp_err: 1, exp_busy: 1'b0};
    ev[1] = '{num: 4'd2,  sop: 1'b0, eop: 1'b0, exp_err: 1, exp_busy: 1'b0};
    ev[2] = '{num: 4'd9,  sop: 1'b1, eop: 1'b0, exp_err: 1, exp_busy: 1'b0};
    ev[3] = '{num: 4'd15, sop: 1'b1, eop: 1'b1, exp_err: 1, exp_busy: 1'b0};
    ev[4] = '{num: 4'd2,  sop: 1'b0, eop: 1'b1, exp_err: 1, exp_busy: 1'b0};
    sc_ref = '{4'b1011, 4'b0110, 4'b0110, 4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b0000};

    ld_if.val = 1'b0; ld_if.sop = 1'b0; ld_if.eop = 1'b0; ld_if.dat = '0; ld_if.ctl = '0;
    out_if.rdy = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out", 64'({out_if.val, out_if.sop, out_if.eop, out_if.ctl, out_if.dat}), 64'd0);
    check("rst_flags", 64'({busy, err, ld_if.rdy}), 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_rdy", 64'({ld_if.rdy, busy}), 64'b10);

    // Test 1: two records, rdy held high
    setup_t1();
    num_in = 4'd2;
    build_exp(2, 16'hA5A5);
    load_recs(2, 16'hA5A5, -1);
    check("load_rdy_drop", 64'({ld_if.rdy, busy}), 64'b01);
    run_replay(1'b0, -1, fv);
    check("first_val_latency", 64'(fv), 64'd2);
    check("t1_scalar_count", 64'(sc_seen.size()), 64'd8);
    for (int i = 0; i < 8 && i < sc_seen.size(); i++)
      check($sformatf("t1_scalar%0d", i), 64'(sc_seen[i]), 64'(sc_ref[i]));

    // Test 2: same load, random output stalls
    load_recs(2, 16'hA5A5, -1);
    run_replay(1'b1, -1, fv);

    // Test 3: single-beat protocol errors in IDLE
    for (int i = 0; i < 5; i++) begin
      e0 = err_cnt;
      vseen = 0;
      num_in = ev[i].num;
      load_beat(16'h5A5A, ev[i].sop, ev[i].eop, 16'h0003);
      ld_if.val = 1'b0;
      repeat (3) begin
        if (out_if.val) vseen++;
        @(negedge clk);
      end
      err_exp += ev[i].exp_err;
      check($sformatf("ev%0d_err", i), 64'(err_cnt - e0), 64'(ev[i].exp_err));
      check($sformatf("ev%0d_busy", i), 64'({busy, ld_if.rdy}), 64'({ev[i].exp_busy, 1'b1}));
      check($sformatf("ev%0d_no_out", i), 64'(vseen), 64'd0);
    end

    // Test 4: eop on beat 4 of record 0, then a clean single-record load
    rand_data(2);
    num_in = 4'd2;
    e0 = err_cnt;
    load_recs(2, 16'h0F0F, 4);
    repeat (2) @(negedge clk);
    err_exp += 1;
    check("bad_eop_err", 64'(err_cnt - e0), 64'd1);
    check("bad_eop_idle", 64'({busy, ld_if.rdy}), 64'b01);
    rand_data(1);
    num_in = 4'd1;
    build_exp(1, 16'h0F0F);
    load_recs(1, 16'h0F0F, -1);
    run_replay(1'b0, -1, fv);

    // Test 5: reset during pass 2, then full reload
    setup_t1();
    num_in = 4'd2;
    build_exp(2, 16'h1234);
    load_recs(2, 16'h1234, -1);
    run_replay(1'b0, 2 * 2 * 7 + 3, fv);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out", 64'({out_if.val, busy}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    load_recs(2, 16'h1234, -1);
    run_replay(1'b0, -1, fv);

    // Test 6: num_in = MAX_IN
    rand_data(MI);
    num_in = 4'(MI);
    build_exp(MI, 16'hC3C3);
    load_recs(MI, 16'hC3C3, -1);
    run_replay(1'b0, -1, fv);
    check("max_last_word", 64'({last_eop, last_dat}), 64'({1'b1, pnt_a[MI*6-1]}));

    // Randomized loads and stalls against the reference model
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, MI);
      c = CB'($urandom);
      rand_data(n);
      num_in = 4'(n);
      build_exp(n, c);
      load_recs(n, c, -1);
      run_replay(1'b1, -1, fv);
    end

    check("total_err_pulses", 64'(err_cnt), 64'(err_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
